gpo_rxcommaalign_ctrl: RTL and testbench

- Control-direction counterpart to the GPI status path: takes the 16-bit processor GPO word and drives a GT channel's rxcommaalignen.
- Runs a comma-alignment sequence on request: assert alignment, qualify a stable byte-alignment, release, and re-arm on loss of alignment.
- Reports done/timeout flags for return to the processor.
- Sits between the PS/PL GPIO block and one transceiver RX channel; one instance per channel.

---
 rtl/gpo_rxcommaalign_ctrl_if.sv | 28 ++
 rtl/gpo_rxcommaalign_ctrl.sv | 154 +++++++++++++++
 tb/tb_gpo_rxcommaalign_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/gpo_rxcommaalign_ctrl_if.sv
// Signal bundle between the processor GPO / GT RX status side and the
// comma-alignment controller of one transceiver channel.
interface gpo_rxcommaalign_ctrl_if;
  logic [15:0] gpo_in;
  logic        rxbyteisaligned_in;
  logic        rxbyterealign_in;
  logic        rxcommaalignen_out;
  logic        align_done_out;
  logic        align_timeout_out;

  modport master (
    output gpo_in,
    output rxbyteisaligned_in,
    output rxbyterealign_in,
    input  rxcommaalignen_out,
    input  align_done_out,
    input  align_timeout_out
  );

  modport slave (
    input  gpo_in,
    input  rxbyteisaligned_in,
    input  rxbyterealign_in,
    output rxcommaalignen_out,
    output align_done_out,
    output align_timeout_out
  );
endinterface

// File: rtl/gpo_rxcommaalign_ctrl.sv
// Per-channel comma-alignment sequencer: a processor GPO request bit drives
// rxcommaalignen through search/qualify/lock, with done and timeout flags back.
module gpo_rxcommaalign_ctrl #(
  parameter int CHANNEL_ID     = 2,
  parameter int STABLE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  gpo_rxcommaalign_ctrl_if.slave    bus
);

  localparam int              REQ_BIT  = CHANNEL_ID + 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);

  generate
    if (CHANNEL_ID < 0 || CHANNEL_ID > 7) begin : g_bad_channel
      $error("CHANNEL_ID must be in 0..7");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
      $error("STABLE_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 2 || (TIMEOUT_CYCLES - 1) >= (2 ** CNT_W)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be >= 2 and TIMEOUT_CYCLES-1 must fit in CNT_W");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEARCH  = 3'd1,
    QUALIFY = 3'd2,
    LOCKED  = 3'd3,
    FAULT   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] stb_cnt_q, stb_cnt_d;
  logic             req_q;
  logic             aligned_ok;
  logic             commaalignen_q, commaalignen_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  // Only the request bit of this channel matters; the rest of the word is
  // shared with other channels and intentionally ignored here.
  logic unused_gpo;
  assign unused_gpo = ^bus.gpo_in;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign aligned_ok = bus.rxbyteisaligned_in & ~bus.rxbyterealign_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= 1'b0;
    end else begin
      req_q <= bus.gpo_in[REQ_BIT];
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    stb_cnt_d = stb_cnt_q;

    if (!req_q) begin
      state_d   = IDLE;
      tmo_cnt_d = '0;
      stb_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = SEARCH;
          tmo_cnt_d = '0;
          stb_cnt_d = '0;
        end
        SEARCH: begin
          tmo_cnt_d = sat_inc(tmo_cnt_q);
          if (tmo_cnt_q == TMO_LAST) begin
            state_d = FAULT;
          end else if (aligned_ok) begin
            state_d   = QUALIFY;
            stb_cnt_d = '0;
          end
        end
        QUALIFY: begin
          // The timeout budget spans the whole attempt, including fallbacks.
          tmo_cnt_d = sat_inc(tmo_cnt_q);
          if (tmo_cnt_q == TMO_LAST) begin
            state_d = FAULT;
          end else if (!aligned_ok) begin
            state_d   = SEARCH;
            stb_cnt_d = '0;
          end else if (stb_cnt_q == STB_LAST) begin
            state_d = LOCKED;
          end else begin
            stb_cnt_d = sat_inc(stb_cnt_q);
          end
        end
        LOCKED: begin
          if (!aligned_ok) begin
            state_d   = SEARCH;
            tmo_cnt_d = '0;
            stb_cnt_d = '0;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d   = IDLE;
          tmo_cnt_d = '0;
          stb_cnt_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same
  // edge as the state itself.
  always_comb begin
    commaalignen_d = (state_d == SEARCH) || (state_d == QUALIFY);
    done_d         = (state_d == LOCKED);
    timeout_d      = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      tmo_cnt_q      <= '0;
      stb_cnt_q      <= '0;
      commaalignen_q <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmo_cnt_q      <= tmo_cnt_d;
      stb_cnt_q      <= stb_cnt_d;
      commaalignen_q <= commaalignen_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
    end
  end

  assign bus.rxcommaalignen_out = commaalignen_q;
  assign bus.align_done_out     = done_q;
  assign bus.align_timeout_out  = timeout_q;

endmodule

// File: tb/tb_gpo_rxcommaalign_ctrl.sv
// Directed bench for the comma-alignment controller, STABLE_CYCLES=4 and
// TIMEOUT_CYCLES=16; outputs compared as {commaalignen, done, timeout}.
module tb_gpo_rxcommaalign_ctrl;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  logic [2:0] obs;
  logic [2:0] exp_o;

  gpo_rxcommaalign_ctrl_if bus ();

  gpo_rxcommaalign_ctrl #(
    .CHANNEL_ID     (2),
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign obs = {bus.rxcommaalignen_out, bus.align_done_out, bus.align_timeout_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle;
    bus.gpo_in             = 16'h0000;
    bus.rxbyteisaligned_in = 1'b0;
    bus.rxbyterealign_in   = 1'b0;
    tick();
    tick();
  endtask

  // Request set; after this returns the edge that entered SEARCH has passed.
  task automatic start_search;
    bus.gpo_in = 16'h0400;
    tick();
    tick();
  endtask

  task automatic test_reset;
    rst                    = 1'b1;
    bus.gpo_in             = 16'hFFFF;
    bus.rxbyteisaligned_in = 1'b0;
    bus.rxbyterealign_in   = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_total++;
      if (obs !== 3'b000) $display("FAIL reset_hold k=%0d got=%b exp=%b", k, obs, 3'b000);
      else n_pass++;
    end
    rst = 1'b0;
    tick();
    n_total++;
    if (obs !== 3'b000) $display("FAIL reset_release_edge1 got=%b exp=%b", obs, 3'b000);
    else n_pass++;
    tick();
    n_total++;
    if (obs !== 3'b100) $display("FAIL reset_release_edge2 got=%b exp=%b", obs, 3'b100);
    else n_pass++;
    go_idle();
  endtask

  // Leaves the DUT LOCKED with aligned held high.
  task automatic test_nominal_lock;
    start_search();
    n_total++;
    if (obs !== 3'b100) $display("FAIL nominal_entry got=%b exp=%b", obs, 3'b100);
    else n_pass++;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_o = (k >= 6) ? 3'b010 : 3'b100;
      n_total++;
      if (obs !== exp_o) $display("FAIL nominal_lock k=%0d got=%b exp=%b", k, obs, exp_o);
      else n_pass++;
      if (k == 1) bus.rxbyteisaligned_in = 1'b1;
    end
  endtask

  task automatic test_relock;
    bus.rxbyterealign_in = 1'b1;
    tick();
    n_total++;
    if (obs !== 3'b100) $display("FAIL relock_edge got=%b exp=%b", obs, 3'b100);
    else n_pass++;
    bus.rxbyterealign_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_o = (k >= 5) ? 3'b010 : 3'b100;
      n_total++;
      if (obs !== exp_o) $display("FAIL relock_seq k=%0d got=%b exp=%b", k, obs, exp_o);
      else n_pass++;
    end
    bus.rxbyteisaligned_in = 1'b0;
    tick();
    n_total++;
    if (obs !== 3'b100) $display("FAIL relock_loss_edge got=%b exp=%b", obs, 3'b100);
    else n_pass++;
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp_o = (k >= 16) ? 3'b001 : 3'b100;
      n_total++;
      if (obs !== exp_o) $display("FAIL relock_fresh_timeout k=%0d got=%b exp=%b", k, obs, exp_o);
      else n_pass++;
    end
    go_idle();
  endtask

  task automatic test_qualify_glitch;
    start_search();
    for (int k = 1; k <= 11; k++) begin
      bus.rxbyteisaligned_in = (k >= 2) && (k != 5);
      tick();
      exp_o = (k >= 10) ? 3'b010 : 3'b100;
      n_total++;
      if (obs !== exp_o) $display("FAIL glitch_lock k=%0d got=%b exp=%b", k, obs, exp_o);
      else n_pass++;
    end
    go_idle();
    start_search();
    for (int k = 1; k <= 17; k++) begin
      bus.rxbyteisaligned_in = ((k % 3) != 0);
      tick();
      exp_o = (k >= 16) ? 3'b001 : 3'b100;
      n_total++;
      if (obs !== exp_o) $display("FAIL glitch_timeout k=%0d got=%b exp=%b", k, obs, exp_o);
      else n_pass++;
    end
    go_idle();
  endtask

  task automatic test_timeout;
    bus.rxbyteisaligned_in = 1'b0;
    start_search();
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_o = (k == 16) ? 3'b001 : 3'b100;
      n_total++;
      if (obs !== exp_o) $display("FAIL timeout_seq k=%0d got=%b exp=%b", k, obs, exp_o);
      else n_pass++;
    end
    bus.gpo_in = 16'h0000;
    tick();
    n_total++;
    if (obs !== 3'b001) $display("FAIL timeout_clear_edge1 got=%b exp=%b", obs, 3'b001);
    else n_pass++;
    tick();
    n_total++;
    if (obs !== 3'b000) $display("FAIL timeout_clear_edge2 got=%b exp=%b", obs, 3'b000);
    else n_pass++;
    bus.gpo_in = 16'h0400;
    tick();
    n_total++;
    if (obs !== 3'b000) $display("FAIL timeout_rearm_edge1 got=%b exp=%b", obs, 3'b000);
    else n_pass++;
    tick();
    n_total++;
    if (obs !== 3'b100) $display("FAIL timeout_rearm_edge2 got=%b exp=%b", obs, 3'b100);
    else n_pass++;
    go_idle();
  endtask

  task automatic test_bit_isolation;
    bus.gpo_in             = 16'hFBFF;
    bus.rxbyteisaligned_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_total++;
      if (obs !== 3'b000) $display("FAIL bit_isolation k=%0d got=%b exp=%b", k, obs, 3'b000);
      else n_pass++;
    end
    go_idle();
  endtask

  task automatic test_reset_mid;
    start_search();
    bus.rxbyteisaligned_in = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_total++;
      if (obs !== 3'b100) $display("FAIL rstmid_qualify k=%0d got=%b exp=%b", k, obs, 3'b100);
      else n_pass++;
    end
    rst = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_total++;
      if (obs !== 3'b000) $display("FAIL rstmid_drop k=%0d got=%b exp=%b", k, obs, 3'b000);
      else n_pass++;
    end
    rst = 1'b0;
    tick();
    n_total++;
    if (obs !== 3'b000) $display("FAIL rstmid_idle got=%b exp=%b", obs, 3'b000);
    else n_pass++;
    tick();
    n_total++;
    if (obs !== 3'b100) $display("FAIL rstmid_restart got=%b exp=%b", obs, 3'b100);
    else n_pass++;
    go_idle();
  endtask

  initial begin
    n_pass                 = 0;
    n_total                = 0;
    rst                    = 1'b1;
    bus.gpo_in             = 16'hFFFF;
    bus.rxbyteisaligned_in = 1'b0;
    bus.rxbyterealign_in   = 1'b0;
    test_reset();
    test_nominal_lock();
    test_relock();
    test_qualify_glitch();
    test_timeout();
    test_bit_isolation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
